// File: rtl/fp_cmd_sequencer_pkg.sv
// fp_cmd_sequencer_pkg: shared types for the front-panel command sequencer
package fp_cmd_sequencer_pkg;
  localparam int WORD_W = 12;
  typedef enum logic [1:0] {LOADPC = 2'b00, LOADAC = 2'b01, DEPOSIT = 2'b10, STEP = 2'b11} fp_op_t;
  typedef enum logic [1:0] {IDLE, ISSUE, RUN} seq_state_t;
  typedef struct packed {
    fp_op_t op;
    logic [WORD_W-1:0] data;
  } fp_cmd_t;
endpackage

// File: rtl/fp_cmd_fifo.sv
// fp_cmd_fifo: synchronous FIFO of front-panel commands, simultaneous push+pop allowed when full
module fp_cmd_fifo
  import fp_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type T = fp_cmd_t
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  T                       din,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clock)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/fp_cmd_sequencer.sv
// fp_cmd_sequencer: queues front-panel commands and issues them to the halted CPU; FP_TIMEOUT_EN enables ISSUE timeout
module fp_cmd_sequencer
  import fp_cmd_sequencer_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int WORD_W = 12,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              loadpc,
  input  logic              loadac,
  input  logic              deposit,
  input  logic              step,
  input  logic              run_sw,
  input  logic [WORD_W-1:0] swreg,
  input  logic              cpu_halted,
  input  logic              cpu_ack,
  input  logic              clr_err,
  output logic              cpu_req,
  output logic [1:0]        cpu_op,
  output logic [WORD_W-1:0] cpu_data,
  output logic              cpu_run,
  output logic              busy,
  output logic              q_full,
  output logic              err_drop,
  output logic              err_timeout
);
  seq_state_t state, next;
  fp_cmd_t din, head, cur;
  logic run_q, rise, push, pop, multi, empty, tmo;
  logic [$clog2(QDEPTH):0] count;
  assign rise = run_sw && !run_q;
  assign push = loadpc || loadac || deposit || step;
  assign multi = (loadpc && (loadac || deposit || step)) || (loadac && (deposit || step)) || (deposit && step);
  assign din.op = loadpc ? LOADPC : loadac ? LOADAC : deposit ? DEPOSIT : STEP;
  assign din.data = swreg;
  assign pop = state == IDLE && !empty;
  fp_cmd_fifo #(.DEPTH(QDEPTH), .T(fp_cmd_t)) u_fifo (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .din(din),
    .dout(head), .full(q_full), .empty(empty), .count(count)
  );
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = (rise && empty) ? RUN : !empty ? ISSUE : IDLE;
      ISSUE:   next = (cpu_ack || tmo) ? IDLE : ISSUE;
      RUN:     next = (cpu_halted || !run_sw) ? IDLE : RUN;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      run_q <= 1'b0;
      cur <= '0;
      err_drop <= 1'b0;
    end else begin
      state <= next;
      run_q <= run_sw;
      if (pop) cur <= head;
      err_drop <= (err_drop && !clr_err) || multi || (push && q_full && !pop);
    end
  end
`ifdef FP_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] tcnt;
  assign tmo = state == ISSUE && !cpu_ack && tcnt == TW'(TIMEOUT_CYC-1);
  always_ff @(posedge clock) begin
    if (reset || state != ISSUE) tcnt <= '0;
    else tcnt <= tcnt + 1'b1;
    if (reset) err_timeout <= 1'b0;
    else err_timeout <= (err_timeout && !clr_err) || tmo;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYC);
  assign tmo = 1'b0;
  assign err_timeout = 1'b0;
`endif
  assign cpu_req = state == ISSUE;
  assign cpu_run = state == RUN;
  assign cpu_op = cur.op;
  assign cpu_data = cur.data;
  assign busy = state != IDLE || count != '0;
endmodule

// File: tb/tb_fp_cmd_sequencer.sv
// tb_fp_cmd_sequencer: directed stimulus with a scoreboard of expected issued commands
module tb_fp_cmd_sequencer;
  import fp_cmd_sequencer_pkg::*;
  logic clock = 0, reset = 1, loadpc = 0, loadac = 0, deposit = 0, step = 0, run_sw = 0;
  logic cpu_halted = 0, cpu_ack = 0, clr_err = 0;
  logic [11:0] swreg = 0;
  logic cpu_req, cpu_run, busy, q_full, err_drop, err_timeout;
  logic [1:0] cpu_op;
  logic [11:0] cpu_data;
  int tests = 0, fails = 0;
  logic [13:0] exp_q[$];

  fp_cmd_sequencer #(.QDEPTH(4), .WORD_W(12), .TIMEOUT_CYC(8)) dut (
    .clock(clock), .reset(reset), .loadpc(loadpc), .loadac(loadac), .deposit(deposit),
    .step(step), .run_sw(run_sw), .swreg(swreg), .cpu_halted(cpu_halted), .cpu_ack(cpu_ack),
    .clr_err(clr_err), .cpu_req(cpu_req), .cpu_op(cpu_op), .cpu_data(cpu_data),
    .cpu_run(cpu_run), .busy(busy), .q_full(q_full), .err_drop(err_drop), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_cmd(fp_op_t op, logic [11:0] sw);
    exp_q.push_back({op, sw});
  endtask

  task automatic pulse(logic [3:0] p, logic [11:0] sw);
    {loadpc, loadac, deposit, step} = p;
    swreg = sw;
    tick();
    {loadpc, loadac, deposit, step} = 4'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!cpu_req && n < 20) begin
      tick();
      n++;
    end
    check("wait_req", cpu_req, 1);
  endtask

  task automatic serve(int hold);
    logic [1:0] op0;
    logic [11:0] d0;
    wait_req();
    op0 = cpu_op;
    d0 = cpu_data;
    for (int i = 1; i < hold; i++) begin
      check("req_held", cpu_req, 1);
      tick();
      check("op_stable", {cpu_op, cpu_data}, {op0, d0});
    end
    check("req_before_ack", cpu_req, 1);
    cpu_ack = 1;
    tick();
    cpu_ack = 0;
    check("req_drop_after_ack", cpu_req, 0);
  endtask

  task automatic clear_errors();
    clr_err = 1;
    tick();
    clr_err = 0;
  endtask

  initial begin
    logic prev;
    logic [13:0] e;
    prev = 0;
    forever begin
      @(negedge clock);
      if (cpu_req && !prev) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_req: op=%0d data=%0o, required no request", cpu_op, cpu_data);
        end else begin
          e = exp_q.pop_front();
          check("issue_op", cpu_op, e[13:12]);
          check("issue_data", cpu_data, e[11:0]);
        end
      end
      prev = cpu_req;
    end
  end

  initial begin
    tick(3);
    check("rst_outputs", {cpu_req, cpu_run, busy, q_full, err_drop, err_timeout}, 0);
    check("rst_op_data", {cpu_op, cpu_data}, 0);
    reset = 0;

    expect_cmd(LOADPC, 12'o0200);
    pulse(4'b1000, 12'o0200);
    serve(3);
    tick();
    check("t1_busy_idle", busy, 0);

    expect_cmd(LOADAC, 12'o1234);
    pulse(4'b0100, 12'o1234);
    wait_req();
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) expect_cmd(DEPOSIT, 12'(i));
      pulse(4'b0010, 12'(i));
      if (i == 4) check("t2_full_no_drop", {q_full, err_drop}, 2'b10);
    end
    check("t2_full_drop", {q_full, err_drop}, 2'b11);
    serve(1);
    for (int i = 0; i < 4; i++) serve(2);
    tick();
    check("t2_drained", {busy, q_full}, 0);
    clear_errors();
    check("t2_clr_err", err_drop, 0);

    expect_cmd(LOADAC, 12'o7777);
    pulse(4'b0101, 12'o7777);
    check("t3_multi_drop", err_drop, 1);
    serve(1);
    tick(3);
    check("t3_step_discarded", {cpu_req, busy}, 0);
    clear_errors();
    check("t3_clr_err", err_drop, 0);
    expect_cmd(LOADPC, 12'o0017);
    clr_err = 1;
    pulse(4'b1010, 12'o0017);
    clr_err = 0;
    check("t3_err_wins_clr", err_drop, 1);
    serve(1);
    clear_errors();
    check("t3_clr_again", err_drop, 0);

    run_sw = 1;
    tick();
    check("t4_run_on", {cpu_run, busy}, 2'b11);
    expect_cmd(STEP, 12'o0042);
    pulse(4'b0001, 12'o0042);
    tick(3);
    check("t4_held_in_run", {cpu_req, cpu_run}, 2'b01);
    cpu_halted = 1;
    tick();
    cpu_halted = 0;
    check("t4_halt_run_off", cpu_run, 0);
    serve(2);
    run_sw = 0;
    tick();
    run_sw = 1;
    tick();
    check("t4_rerun", cpu_run, 1);
    run_sw = 0;
    tick();
    check("t4_switch_off", cpu_run, 0);

`ifdef FP_TIMEOUT_EN
    begin
      int n;
      n = 0;
      expect_cmd(LOADPC, 12'o0555);
      pulse(4'b1000, 12'o0555);
      wait_req();
      while (cpu_req && n < 20) begin
        tick();
        n++;
      end
      check("t5_timeout_len", n, 8);
      check("t5_err_timeout", err_timeout, 1);
      check("t5_idle", busy, 0);
      clear_errors();
      check("t5_clr_timeout", err_timeout, 0);
    end
`else
    check("t5_no_timeout", err_timeout, 0);
`endif

    expect_cmd(LOADAC, 12'o3333);
    pulse(4'b0100, 12'o3333);
    wait_req();
    pulse(4'b1001, 12'o0001);
    check("t6_pre_state", {err_drop, busy, cpu_req}, 3'b111);
    reset = 1;
    tick();
    check("t6_reset_flags", {cpu_req, cpu_run, busy, q_full, err_drop, err_timeout}, 0);
    check("t6_reset_op_data", {cpu_op, cpu_data}, 0);
    reset = 0;
    tick(4);
    check("t6_queue_flushed", {cpu_req, busy}, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
